// File: rtl/uart_rx_param.sv
// UART receiver with configurable data width and prescale. Each bit is decided by a 3-sample majority vote.
// It supports 1 or 2 stop bits, recovers from a held-low break, and delivers frames over a valid/ready handshake.
module uart_rx_param #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  RX_IN,
  input  logic [PRESCALE_W-1:0] prescale,
  input  logic                  parity_enable,
  input  logic                  parity_type,
  input  logic                  two_stop,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  parity_error,
  output logic                  stop_error,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  overrun
);

  localparam int BIT_W = (DATA_WIDTH > 8) ? 4 : 3;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, WAIT_HIGH} state_t;

  state_t                  state;
  logic [1:0]              sync_q;
  logic                    rxs;
  logic [PRESCALE_W-1:0]   edge_cnt;
  logic [BIT_W-1:0]        bit_cnt;
  logic [PRESCALE_W-1:0]   p_q;
  logic                    par_en_q;
  logic                    par_type_q;
  logic                    two_stop_q;
  logic [DATA_WIDTH-1:0]   shift_q;
  logic                    par_acc_q;
  logic                    par_err_q;
  logic                    stop_acc_q;
  logic                    samp0_q;
  logic                    samp1_q;

  logic [PRESCALE_W-1:0]   half;
  logic                    at_s0;
  logic                    at_s1;
  logic                    at_dec;
  logic                    at_last;
  logic                    maj;
  logic                    last_stop;
  logic                    stop_err_now;
  logic                    done;

  // The third vote is taken straight from rxs so the decided bit is already
  // registered by the time edge_cnt reaches P/2+2.
  assign rxs          = sync_q[1];
  assign half         = p_q >> 1;
  assign at_s0        = (edge_cnt == half - PRESCALE_W'(1));
  assign at_s1        = (edge_cnt == half);
  assign at_dec       = (edge_cnt == half + PRESCALE_W'(1));
  assign at_last      = (edge_cnt == p_q - PRESCALE_W'(1));
  assign maj          = (samp0_q & samp1_q) | (samp0_q & rxs) | (samp1_q & rxs);
  assign last_stop    = (bit_cnt == BIT_W'(two_stop_q));
  assign stop_err_now = stop_acc_q | ~maj;
  assign done         = (state == STOP) && at_dec && last_stop;

  // NOTE: every register below is updated with <= so all flops see the
  // pre-edge values of each other, matching real hardware.
  always_ff @(posedge clk) begin
    if (!rstn) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], RX_IN};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_q        <= '0;
      par_en_q   <= 1'b0;
      par_type_q <= 1'b0;
      two_stop_q <= 1'b0;
      shift_q    <= '0;
      par_acc_q  <= 1'b0;
      par_err_q  <= 1'b0;
      stop_acc_q <= 1'b0;
      samp0_q    <= 1'b1;
      samp1_q    <= 1'b1;
    end else begin
      if (state != IDLE && state != WAIT_HIGH) begin
        edge_cnt <= at_last ? '0 : edge_cnt + PRESCALE_W'(1);
        if (at_s0) samp0_q <= rxs;
        if (at_s1) samp1_q <= rxs;
      end
      case (state)
        IDLE: begin
          if (!rxs) begin
            state      <= START;
            edge_cnt   <= PRESCALE_W'(1);
            bit_cnt    <= '0;
            p_q        <= prescale;
            par_en_q   <= parity_enable;
            par_type_q <= parity_type;
            two_stop_q <= two_stop;
            par_acc_q  <= 1'b0;
            par_err_q  <= 1'b0;
            stop_acc_q <= 1'b0;
          end
        end
        START: begin
          if (at_dec && maj) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (at_last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (at_dec) begin
            shift_q   <= {maj, shift_q[DATA_WIDTH-1:1]};
            par_acc_q <= par_acc_q ^ maj;
          end
          if (at_last) begin
            if (bit_cnt == BIT_W'(DATA_WIDTH - 1)) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end
        PARITY: begin
          if (at_dec)  par_err_q <= ((par_acc_q ^ maj) != par_type_q);
          if (at_last) state <= STOP;
        end
        STOP: begin
          // The last stop bit ends at its decision point so a start bit
          // following immediately is still seen from IDLE.
          if (at_dec) begin
            if (last_stop) begin
              state    <= stop_err_now ? WAIT_HIGH : IDLE;
              edge_cnt <= '0;
            end else begin
              stop_acc_q <= stop_err_now;
            end
          end else if (at_last) begin
            bit_cnt <= bit_cnt + BIT_W'(1);
          end
        end
        WAIT_HIGH: if (rxs) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      P_DATA       <= '0;
      parity_error <= 1'b0;
      stop_error   <= 1'b0;
      data_valid   <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (done) begin
        if (!data_valid || data_ready) begin
          P_DATA       <= shift_q;
          parity_error <= par_err_q;
          stop_error   <= stop_err_now;
          data_valid   <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end
    end
  end

endmodule
